uart_tx_buf: RTL
================

UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (5..8).
REQ-002 SHALL have parameter DIV_W, default 16, width of the bit-time divisor.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, transmit buffer entries (power of two, >=2).
REQ-004 SHALL have port CLK  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port RESET_N  input  1  reset; synchronous and active-low.
REQ-006 SHALL have port DIVISOR  input  DIV_W  bit time in CLK cycles.
REQ-007 SHALL have port PARITY_MODE  input  2  0=none, 1=even, 2=odd, 3=mark (parity bit forced 1).
REQ-008 SHALL have port STOP2  input  1  1=two stop bits, 0=one.
REQ-009 SHALL have port DATA  input  DATA_W  character to send.
REQ-010 SHALL have port VALID  input  1  DATA is offered.
REQ-011 SHALL have port READY  output  1  buffer can accept; a transfer occurs on a cycle with VALID&READY.
REQ-012 SHALL have port LEVEL  output  $clog2(FIFO_DEPTH)+1  characters buffered, excluding the one being shifted.
REQ-013 SHALL have port BUSY  output  1  a frame is on the line or the buffer is non-empty.
REQ-014 SHALL have port TX  output  1  serial line, registered, idle high.

Function
REQ-015 SHALL frame each character as: start bit (0), DATA_W data bits LSB first, optional parity bit, one or two stop bits (1); each bit lasts exactly max(DIVISOR,2) CLK cycles.
REQ-016 SHALL treat DIVISOR values 0 and 1 as 2.
REQ-017 SHALL sample DIVISOR, PARITY_MODE and STOP2 once, on the cycle a frame leaves IDLE, and hold them for that frame; changes mid-frame SHALL NOT affect it.
REQ-018 SHALL use FSM states IDLE, START, DATA, PARITY, STOP1, STOP2; IDLE->START when buffer non-empty; START->DATA, DATA->DATA until DATA_W bits sent; then ->PARITY if mode!=0, else ->STOP1; PARITY->STOP1; STOP1->STOP2 if STOP2 latched, else end of frame; STOP2 -> end of frame.
REQ-019 SHALL, at end of frame, go directly to START if the buffer is non-empty (no idle gap), else to IDLE.
REQ-020 SHALL compute parity as XOR of the DATA_W data bits (even), its inverse (odd), or constant 1 (mark).
REQ-021 SHALL drive TX low exactly 2 CLK edges after the edge accepting a character into an empty buffer while in IDLE.
REQ-022 SHALL deassert READY when LEVEL==FIFO_DEPTH; a pop on the same cycle SHALL NOT make READY high that cycle.
REQ-023 SHALL allow simultaneous push and pop when not full, leaving LEVEL unchanged.
REQ-024 SHALL ignore DATA while VALID is low or READY is low.
REQ-025 SHALL count bit time and bit index with wrap-free counters reloaded at each bit boundary; counter width SHALL be DIV_W.

Reset
REQ-026 SHALL, on a cycle with RESET_N low, set state=IDLE, TX=1, READY=1, LEVEL=0, BUSY=0, and empty the buffer on the next edge, including mid-frame; the aborted character SHALL be discarded.
REQ-027 SHALL hold TX high for every cycle RESET_N is low.

Configuration
REQ-028 SHALL honour macro UART_TX_BUF_FIFO_EN: defined -> FIFO_DEPTH-entry buffer as above.
REQ-029 SHALL, without UART_TX_BUF_FIFO_EN, replace the buffer with a single holding register: READY high only when it is empty, LEVEL 0 or 1, FIFO_DEPTH ignored.

Structure
REQ-030 SHALL take the FSM state enum, the parity-mode typedef and PARITY_NONE/EVEN/ODD/MARK constants from shared package uart_pkg.
REQ-031 SHALL implement the buffer as sub-module uart_tx_fifo (parameters DATA_W, FIFO_DEPTH; push/pop/full/empty/level).

Verification
REQ-032 SHALL test DIVISOR=4, mode 0, STOP2=0, DATA=0x55 -> TX: 4 cycles 0, bits 1,0,1,0,1,0,1,0 at 4 cycles each, 4 cycles 1; BUSY low afterwards.
REQ-033 SHALL test DIVISOR=3, odd parity, DATA=0x07 -> parity bit 0; even parity -> parity bit 1; mark -> 1.
REQ-034 SHALL test burst of 5 VALID words with FIFO_DEPTH=4, DIVISOR=2 -> READY drops after 4 accepted while first frame shifts; 5 frames back-to-back with no idle cycle between stop and start.
REQ-035 SHALL test STOP2=1, DIVISOR=5 -> stop interval 10 cycles; toggling STOP2 mid-frame does not change current frame.
REQ-036 SHALL test RESET_N low during data bit 3 -> TX=1 on next edge, LEVEL=0, READY=1, no residual frame after release.
REQ-037 SHALL test DIVISOR=0 -> every bit lasts 2 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_pkg                                                        |
// | Brief    : Shared UART types: transmitter FSM states and parity modes.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } uart_state_t;

    typedef logic [1:0] parity_mode_t;

    localparam parity_mode_t PARITY_NONE = 2'd0;
    localparam parity_mode_t PARITY_EVEN = 2'd1;
    localparam parity_mode_t PARITY_ODD  = 2'd2;
    localparam parity_mode_t PARITY_MARK = 2'd3;

    // data_xor is the XOR-reduction of the character's data bits
    function automatic logic parity_bit(input parity_mode_t mode, input logic data_xor);
        logic bit_v;
        case (mode)
            PARITY_EVEN: bit_v = data_xor;
            PARITY_ODD:  bit_v = ~data_xor;
            PARITY_MARK: bit_v = 1'b1;
            default:     bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                                    |
// | Brief    : Power-of-two transmit buffer with occupancy count.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          PUSH,
    input  logic [DATA_W-1:0]             PUSH_DATA,
    input  logic                          POP,
    output logic [DATA_W-1:0]             POP_DATA,
    output logic                          FULL,
    output logic                          EMPTY,
    output logic [$clog2(FIFO_DEPTH):0]   LEVEL
);

    localparam int c_AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_level;
    logic              w_push;
    logic              w_pop;

    assign w_push   = PUSH && !FULL;
    assign w_pop    = POP && !EMPTY;
    assign FULL     = (r_level == (c_AW+1)'(FIFO_DEPTH));
    assign EMPTY    = (r_level == '0);
    assign LEVEL    = r_level;
    assign POP_DATA = r_mem[r_rd_ptr];

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= PUSH_DATA;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_buf                                                     |
// | Brief    : Buffered UART transmitter; UART_TX_BUF_FIFO_EN selects a        |
// |            FIFO_DEPTH-entry FIFO, otherwise a single holding register.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic [DIV_W-1:0]              DIVISOR,
    input  logic [1:0]                    PARITY_MODE,
    input  logic                          STOP2,
    input  logic [DATA_W-1:0]             DATA,
    input  logic                          VALID,
    output logic                          READY,
    output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
    output logic                          BUSY,
    output logic                          TX
);

    localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [DATA_W-1:0]   w_pop_data;
    logic [c_LVL_W-1:0]  w_level;

    uart_state_t         r_state;
    uart_state_t         w_state_nxt;
    logic [DIV_W-1:0]    r_cnt;
    logic [DIV_W-1:0]    r_div;
    logic [DIV_W-1:0]    r_bit_idx;
    parity_mode_t        r_mode;
    logic                r_stop2;
    logic                r_par;
    logic                r_tx;
    logic [DATA_W-1:0]   r_shift;
    logic [DIV_W-1:0]    w_div_eff;
    logic                w_bit_end;
    logic                w_last_bit;
    logic                w_frame_end;
    logic                w_tx_nxt;

    assign w_push = VALID && !w_full;
    assign READY  = !w_full;
    assign LEVEL  = w_level;
    assign BUSY   = (r_state != ST_IDLE) || !w_empty;
    assign TX     = r_tx;

`ifdef UART_TX_BUF_FIFO_EN
    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .PUSH      (w_push),
        .PUSH_DATA (DATA),
        .POP       (w_pop),
        .POP_DATA  (w_pop_data),
        .FULL      (w_full),
        .EMPTY     (w_empty),
        .LEVEL     (w_level)
    );
`else
    logic                r_hold_valid;
    logic [DATA_W-1:0]   r_hold_data;

    assign w_full     = r_hold_valid;
    assign w_empty    = !r_hold_valid;
    assign w_pop_data = r_hold_data;
    assign w_level    = c_LVL_W'(r_hold_valid);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (w_push) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= DATA;
        end else if (w_pop) begin
            r_hold_valid <= 1'b0;
        end
    end
`endif

    assign w_div_eff  = (DIVISOR < DIV_W'(2)) ? DIV_W'(2) : DIVISOR;
    assign w_bit_end  = (r_cnt == '0);
    assign w_last_bit = (r_bit_idx == DIV_W'(DATA_W - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_frame_end = 1'b0;
        w_tx_nxt    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = ST_START;
                    w_pop       = 1'b1;
                end
            end
            ST_START: begin
                w_tx_nxt = 1'b0;
                if (w_bit_end) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_bit_end && w_last_bit) begin
                    w_state_nxt = (r_mode != PARITY_NONE) ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: begin
                w_tx_nxt = r_par;
                if (w_bit_end) w_state_nxt = ST_STOP1;
            end
            ST_STOP1: begin
                if (w_bit_end) begin
                    if (r_stop2) w_state_nxt = ST_STOP2;
                    else         w_frame_end = 1'b1;
                end
            end
            ST_STOP2: begin
                if (w_bit_end) w_frame_end = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Chain straight into the next start bit when a character is waiting
        if (w_frame_end) begin
            if (!w_empty) begin
                w_state_nxt = ST_START;
                w_pop       = 1'b1;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state   <= ST_IDLE;
            r_tx      <= 1'b1;
            r_cnt     <= '0;
            r_div     <= DIV_W'(2);
            r_bit_idx <= '0;
            r_mode    <= PARITY_NONE;
            r_stop2   <= 1'b0;
            r_par     <= 1'b0;
            r_shift   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            if (w_pop) begin
                // Frame configuration is frozen here for the whole character
                r_div     <= w_div_eff;
                r_mode    <= PARITY_MODE;
                r_stop2   <= STOP2;
                r_par     <= parity_bit(PARITY_MODE, ^w_pop_data);
                r_shift   <= w_pop_data;
                r_cnt     <= w_div_eff - 1'b1;
                r_bit_idx <= '0;
            end else if (r_state != ST_IDLE) begin
                if (w_bit_end) begin
                    r_cnt <= r_div - 1'b1;
                    if (r_state == ST_DATA) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
